pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/cpu_types_pkg.sv | 49 ++++
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_control.sv | 161 ++++++++++++++++
 tb/tb_pipeline_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word widths, pipeline-control state and the
// latch-control bundle driven by pipeline_control.
package cpu_types_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pcstate_t;

    typedef struct packed {
        logic pc_en;
        logic fl_en;
        logic dl_en;
        logic el_en;
        logic ml_en;
        logic fl_flush;
        logic dl_flush;
        logic el_flush;
        logic ml_flush;
    } ctrl_t;

    function automatic ctrl_t ctrl_fill(logic en, logic flush);
        ctrl_t c;
        c.pc_en    = en;
        c.fl_en    = en;
        c.dl_en    = en;
        c.el_en    = en;
        c.ml_en    = en;
        c.fl_flush = flush;
        c.dl_flush = flush;
        c.el_flush = flush;
        c.ml_flush = flush;
        return c;
    endfunction

    function automatic word_t sat_inc(word_t v);
        return (v == WORD_MAX) ? v : v + word_t'(1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an EX-stage load whose destination feeds an ID-stage source.
// Register 0 never creates a hazard since it is hardwired.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dmemREN,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     load_use
);

    logic wsel_nz;
    logic src_hit;

    always_comb begin
        wsel_nz  = (ex_wsel != '0);
        src_hit  = (ex_wsel == id_rs) || (ex_wsel == id_rt);
        load_use = ex_dmemREN && wsel_nz && src_hit;
    end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush/halt control for the five-stage pipeline.
// Tracks outstanding data accesses and a sticky halt with a 3-state FSM.
module pipeline_control
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     ex_dmemREN,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     mem_dmemREN,
    input  logic     mem_dmemWEN,
    input  logic     mem_redirect,
    input  logic     mem_halt,
    output logic     pc_en,
    output logic     fl_en,
    output logic     dl_en,
    output logic     el_en,
    output logic     ml_en,
    output logic     fl_flush,
    output logic     dl_flush,
    output logic     el_flush,
    output logic     ml_flush,
    output logic     dmem_req,
    output logic     halt,
    output word_t    stall_count
);

    pcstate_t state_q;
    pcstate_t next_state;
    logic     halt_q;
    word_t    stall_q;
    ctrl_t    ctrl;
    logic     dreq;

    logic mem_pending;
    logic is_halt;
    logic memstall;
    logic load_use;

    logic sel_halt;
    logic sel_ms;
    logic sel_rd;
    logic sel_lu;
    logic sel_fs;
    logic sel_norm;

    load_use_detect u_lud (
        .ex_dmemREN (ex_dmemREN),
        .ex_wsel    (ex_wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .load_use   (load_use)
    );

    // One-hot priority select so the decoder below stays unique
    always_comb begin
        mem_pending = mem_dmemREN || mem_dmemWEN;
        is_halt     = (state_q == HALT);
        memstall    = !is_halt && mem_pending && !dhit;
        sel_halt    = is_halt;
        sel_ms      = !is_halt && memstall;
        sel_rd      = !is_halt && !memstall && mem_redirect;
        sel_lu      = !is_halt && !memstall && !mem_redirect
                    && load_use;
        sel_fs      = !is_halt && !memstall && !mem_redirect
                    && !load_use && !ihit;
        sel_norm    = !is_halt && !memstall && !mem_redirect
                    && !load_use && ihit;
    end

    always_comb begin
        next_state = state_q;
        unique case (state_q)
            RUN, DWAIT: begin
                if (mem_halt && (!mem_pending || dhit))
                    next_state = HALT;
                else if (memstall)
                    next_state = DWAIT;
                else
                    next_state = RUN;
            end
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        ctrl = ctrl_fill(1'b1, 1'b0);
        dreq = mem_pending;
        if (RST) begin
            ctrl = ctrl_fill(1'b0, 1'b1);
            dreq = 1'b0;
        end else begin
            unique case (1'b1)
                sel_halt: begin
                    ctrl = ctrl_fill(1'b0, 1'b0);
                    dreq = 1'b0;
                end
                sel_ms: begin
                    ctrl = ctrl_fill(1'b0, 1'b0);
                end
                sel_rd: begin
                    ctrl          = ctrl_fill(1'b1, 1'b0);
                    ctrl.fl_flush = 1'b1;
                    ctrl.dl_flush = 1'b1;
                    ctrl.el_flush = 1'b1;
                end
                sel_lu: begin
                    ctrl          = ctrl_fill(1'b1, 1'b0);
                    ctrl.pc_en    = 1'b0;
                    ctrl.fl_en    = 1'b0;
                    ctrl.dl_flush = 1'b1;
                end
                sel_fs: begin
                    ctrl          = ctrl_fill(1'b1, 1'b0);
                    ctrl.pc_en    = 1'b0;
                    ctrl.fl_flush = 1'b1;
                end
                sel_norm: begin
                    ctrl = ctrl_fill(1'b1, 1'b0);
                end
                default: begin
                    ctrl = ctrl_fill(1'b1, 1'b0);
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= next_state;
            halt_q  <= (next_state == HALT);
            if (!ctrl.pc_en && !is_halt)
                stall_q <= sat_inc(stall_q);
        end
    end

    always_comb begin
        pc_en       = ctrl.pc_en;
        fl_en       = ctrl.fl_en;
        dl_en       = ctrl.dl_en;
        el_en       = ctrl.el_en;
        ml_en       = ctrl.ml_en;
        fl_flush    = ctrl.fl_flush;
        dl_flush    = ctrl.dl_flush;
        el_flush    = ctrl.el_flush;
        ml_flush    = ctrl.ml_flush;
        dmem_req    = dreq;
        halt        = halt_q;
        stall_count = stall_q;
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control: a driver queues the
// hand-computed response per cycle, a monitor pops and compares it.
module tb_pipeline_control;
    import cpu_types_pkg::*;

    logic     CLK;
    logic     RST;
    logic     ihit;
    logic     dhit;
    logic     ex_dmemREN;
    regbits_t ex_wsel;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     mem_dmemREN;
    logic     mem_dmemWEN;
    logic     mem_redirect;
    logic     mem_halt;
    logic     pc_en;
    logic     fl_en;
    logic     dl_en;
    logic     el_en;
    logic     ml_en;
    logic     fl_flush;
    logic     dl_flush;
    logic     el_flush;
    logic     ml_flush;
    logic     dmem_req;
    logic     halt;
    word_t    stall_count;

    pipeline_control dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .ex_dmemREN   (ex_dmemREN),
        .ex_wsel      (ex_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .mem_dmemREN  (mem_dmemREN),
        .mem_dmemWEN  (mem_dmemWEN),
        .mem_redirect (mem_redirect),
        .mem_halt     (mem_halt),
        .pc_en        (pc_en),
        .fl_en        (fl_en),
        .dl_en        (dl_en),
        .el_en        (el_en),
        .ml_en        (ml_en),
        .fl_flush     (fl_flush),
        .dl_flush     (dl_flush),
        .el_flush     (el_flush),
        .ml_flush     (ml_flush),
        .dmem_req     (dmem_req),
        .halt         (halt),
        .stall_count  (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, fl_en, dl_en, el_en, ml_en, fl_fl, dl_fl, el_fl, ml_fl}
    localparam logic [8:0] C_RST  = 9'b0_0000_1111;
    localparam logic [8:0] C_NORM = 9'b1_1111_0000;
    localparam logic [8:0] C_MS   = 9'b0_0000_0000;
    localparam logic [8:0] C_HALT = 9'b0_0000_0000;
    localparam logic [8:0] C_LU   = 9'b0_0111_0100;
    localparam logic [8:0] C_FS   = 9'b0_1111_1000;
    localparam logic [8:0] C_RD   = 9'b1_1111_1110;

    typedef struct {
        string      nm;
        logic [8:0] ctrl;
        logic       dm;
        logic       hl;
        word_t      cnt;
        pcstate_t   st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string nm, string fld, logic [31:0] got,
                       logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", nm, fld, got, want);
        end
    endtask

    always @(negedge CLK) begin
        #2;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "ctrl",
                32'({pc_en, fl_en, dl_en, el_en, ml_en,
                     fl_flush, dl_flush, el_flush, ml_flush}),
                32'(e.ctrl));
            chk(e.nm, "dmem_req", 32'(dmem_req), 32'(e.dm));
            chk(e.nm, "halt", 32'(halt), 32'(e.hl));
            chk(e.nm, "stall_count", stall_count, e.cnt);
            chk(e.nm, "state", 32'(dut.state_q), 32'(e.st));
        end
    end

    // in: {rst, ihit, dhit, exr, ren, wen, redir, mh}
    task automatic step(string nm, logic [7:0] in, regbits_t ew,
                        regbits_t rs, regbits_t rt, bit preload,
                        logic [8:0] c, logic dm, logic hl, word_t cnt,
                        pcstate_t st);
        exp_t e;
        @(negedge CLK);
        if (preload)
            force dut.stall_q = 32'hFFFF_FFFE;
        RST          = in[7];
        ihit         = in[6];
        dhit         = in[5];
        ex_dmemREN   = in[4];
        mem_dmemREN  = in[3];
        mem_dmemWEN  = in[2];
        mem_redirect = in[1];
        mem_halt     = in[0];
        ex_wsel      = ew;
        id_rs        = rs;
        id_rt        = rt;
        e.nm  = nm;
        e.ctrl = c;
        e.dm  = dm;
        e.hl  = hl;
        e.cnt = cnt;
        e.st  = st;
        q.push_back(e);
        if (preload) begin
            #1;
            release dut.stall_q;
        end
    endtask

    localparam word_t FE = 32'hFFFF_FFFE;
    localparam word_t FF = 32'hFFFF_FFFF;

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; ex_dmemREN = 1'b0;
        ex_wsel = '0; id_rs = '0; id_rt = '0; mem_dmemREN = 1'b0;
        mem_dmemWEN = 1'b0; mem_redirect = 1'b0; mem_halt = 1'b0;

        step("reset",     8'b1100_0000, 0, 0, 0, 0, C_RST,  0, 0, 0, RUN);
        step("normal",    8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 0, RUN);
        step("ld_miss1",  8'b0100_1000, 0, 0, 0, 0, C_MS,   1, 0, 0, RUN);
        step("ld_miss2",  8'b0100_1000, 0, 0, 0, 0, C_MS,   1, 0, 1, DWAIT);
        step("ld_miss3",  8'b0100_1000, 0, 0, 0, 0, C_MS,   1, 0, 2, DWAIT);
        step("ld_hit",    8'b0110_1000, 0, 0, 0, 0, C_NORM, 1, 0, 3, DWAIT);
        step("idle",      8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 3, RUN);
        step("lu_rt",     8'b0101_0000, 5, 0, 5, 0, C_LU,   0, 0, 3, RUN);
        step("after_lu",  8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 4, RUN);
        step("lu_r0",     8'b0101_0000, 0, 0, 0, 0, C_NORM, 0, 0, 4, RUN);
        step("lu_rs",     8'b0101_0000, 7, 7, 2, 0, C_LU,   0, 0, 4, RUN);
        step("lu_nomat",  8'b0101_0000, 7, 3, 2, 0, C_NORM, 0, 0, 5, RUN);
        step("fetch_st",  8'b0000_0000, 0, 0, 0, 0, C_FS,   0, 0, 5, RUN);
        step("after_fs",  8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 6, RUN);
        step("rd_imiss",  8'b0000_0010, 0, 0, 0, 0, C_RD,   0, 0, 6, RUN);
        step("rd_dmiss",  8'b0100_1010, 0, 0, 0, 0, C_MS,   1, 0, 6, RUN);
        step("rd_dhit",   8'b0110_1010, 0, 0, 0, 0, C_RD,   1, 0, 7, DWAIT);
        step("rd_over_lu",8'b0101_0010, 3, 3, 0, 0, C_RD,   0, 0, 7, RUN);
        step("sat_pre",   8'b0000_0000, 0, 0, 0, 1, C_FS,   0, 0, FE, RUN);
        step("sat_1",     8'b0000_0000, 0, 0, 0, 0, C_FS,   0, 0, FF, RUN);
        step("sat_2",     8'b0000_0000, 0, 0, 0, 0, C_FS,   0, 0, FF, RUN);
        step("sat_hold",  8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, FF, RUN);
        step("dw_miss1",  8'b0100_1000, 0, 0, 0, 0, C_MS,   1, 0, FF, RUN);
        step("dw_miss2",  8'b0100_1000, 0, 0, 0, 0, C_MS,   1, 0, FF, DWAIT);
        step("dw_reset",  8'b1100_1000, 0, 0, 0, 0, C_RST,  0, 0, 0, RUN);
        step("post_rst",  8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 0, RUN);
        step("hs_miss1",  8'b0100_0101, 0, 0, 0, 0, C_MS,   1, 0, 0, RUN);
        step("hs_miss2",  8'b0100_0101, 0, 0, 0, 0, C_MS,   1, 0, 1, DWAIT);
        step("hs_hit",    8'b0110_0101, 0, 0, 0, 0, C_NORM, 1, 0, 2, DWAIT);
        step("halted1",   8'b0100_0101, 0, 0, 0, 0, C_HALT, 0, 1, 2, HALT);
        step("halted2",   8'b0000_0000, 0, 0, 0, 0, C_HALT, 0, 1, 2, HALT);
        step("halted3",   8'b0100_1010, 0, 0, 0, 0, C_HALT, 0, 1, 2, HALT);
        step("halt_rst",  8'b1100_0000, 0, 0, 0, 0, C_RST,  0, 0, 0, RUN);
        step("final",     8'b0100_0000, 0, 0, 0, 0, C_NORM, 0, 0, 0, RUN);

        repeat (3) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
